// File: rtl/game_pkg.sv
// Shared game constants and state type for the pacing stage and the horizon-line renderer.
package game_pkg;

  localparam int SPEED_SCALE = 1024;

  localparam int DEFAULT_INIT_SPEED = 6 * SPEED_SCALE;
  localparam int DEFAULT_MAX_SPEED  = 13 * SPEED_SCALE;
  localparam int DEFAULT_ACCEL      = 1;
  localparam int DEFAULT_POINT_DIST = 40 * SPEED_SCALE;
  localparam int DEFAULT_MAX_SCORE  = 99999;

  typedef enum logic [1:0] {
    WAITING,
    RUNNING,
    CRASHED
  } game_state_t;

endpackage

// File: rtl/game_speed_ctrl_score_counter.sv
// Distance accumulator that converts travelled sub-pixels into saturating score points.
module score_counter
  import game_pkg::*;
#(
  parameter int POINT_DIST = DEFAULT_POINT_DIST,
  parameter int MAX_SCORE  = DEFAULT_MAX_SCORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        step,
  input  logic [14:0] speed,
  output logic [16:0] score
);

  logic [16:0] acc;
  logic [16:0] sum;

  // Speed stays below POINT_DIST, so a single update can earn at most one point.
  assign sum = acc + {2'b00, speed};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc   <= '0;
      score <= '0;
    end else if (step) begin
      if (sum >= 17'(POINT_DIST)) begin
        acc <= sum - 17'(POINT_DIST);
        if (score < 17'(MAX_SCORE)) begin
          score <= score + 17'd1;
        end
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/game_speed_ctrl.sv
// Paces scrolling objects: turns frame ticks into update pulses, ramps speed, tracks score.
module game_speed_ctrl
  import game_pkg::*;
#(
  parameter int INIT_SPEED = DEFAULT_INIT_SPEED,
  parameter int MAX_SPEED  = DEFAULT_MAX_SPEED,
  parameter int ACCEL      = DEFAULT_ACCEL,
  parameter int POINT_DIST = DEFAULT_POINT_DIST,
  parameter int MAX_SCORE  = DEFAULT_MAX_SCORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        crash,
  output logic        update,
  output logic [14:0] speed,
  output logic [16:0] score,
  output logic        running
);

  game_state_t state;
  logic        tick_pending;
  logic [15:0] speed_sum;
  logic [14:0] speed_next;
  logic        clear;
  logic        step;

  // Add one bit wider than the output so saturation catches the carry instead of wrapping.
  assign speed_sum  = {1'b0, speed} + 16'(ACCEL);
  assign speed_next = (speed_sum > 16'(MAX_SPEED)) ? 15'(MAX_SPEED) : speed_sum[14:0];

  assign update = tick_pending;
  assign clear  = start && !crash && (state != RUNNING);
  assign step   = tick_pending && !crash && (state == RUNNING);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAITING;
      tick_pending <= 1'b0;
      speed        <= '0;
      running      <= 1'b0;
    end else if (crash) begin
      state        <= CRASHED;
      tick_pending <= 1'b0;
      running      <= 1'b0;
    end else begin
      case (state)
        RUNNING: begin
          tick_pending <= frame_tick;
          if (tick_pending) begin
            speed <= speed_next;
          end
        end
        WAITING, CRASHED: begin
          tick_pending <= 1'b0;
          if (start) begin
            state   <= RUNNING;
            speed   <= 15'(INIT_SPEED);
            running <= 1'b1;
          end
        end
        default: begin
          state        <= WAITING;
          tick_pending <= 1'b0;
          running      <= 1'b0;
        end
      endcase
    end
  end

  score_counter #(
    .POINT_DIST(POINT_DIST),
    .MAX_SCORE (MAX_SCORE)
  ) u_score_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .step (step),
    .speed(speed),
    .score(score)
  );

endmodule
